// File: rtl/spike_event_encoder.sv
// spike_event_encoder: latches per-column spike pulses, picks one pending
// column per cycle in round-robin order and queues {column, timestamp}
// address-events in a FIFO with a valid/ready consumer interface.
module spike_event_encoder #(
  parameter int unsigned NUM_COLS   = 1,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ADDR_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned LVL_W     = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] spike_in,
  input  logic                clear_overflow,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [ADDR_W-1:0]   event_addr,
  output logic [TS_WIDTH-1:0] event_time,
  output logic                overflow,
  output logic [LVL_W-1:0]    fifo_level
);

  logic [TS_WIDTH-1:0] ts_cnt;
  logic [NUM_COLS-1:0] pending;
  logic [TS_WIDTH-1:0] ts_reg [NUM_COLS];
  logic [ADDR_W-1:0]   ptr;

  logic                grant;
  logic [ADDR_W-1:0]   grant_idx;
  logic [NUM_COLS-1:0] grant_mask;
  logic                drop;

  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] fifo_time [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    count;
  logic                fifo_full;
  logic                pop;

  // Column index reached by stepping 'off' places from the rotating pointer.
  function automatic logic [ADDR_W-1:0] col_at(input logic [ADDR_W-1:0] base,
                                               input int unsigned off);
    return ADDR_W'((32'(base) + off) % NUM_COLS);
  endfunction

  assign fifo_full   = (count == LVL_W'(FIFO_DEPTH));
  assign event_valid = (count != '0);
  assign pop         = event_valid && event_ready;
  assign event_addr  = fifo_addr[rd_ptr];
  assign event_time  = fifo_time[rd_ptr];
  assign fifo_level  = count;

  // Free-running timestamp counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  // Round-robin arbiter: first pending column at or after ptr; blocked when full.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
        if (!grant && pending[col_at(ptr, i)]) begin
          grant     = 1'b1;
          grant_idx = col_at(ptr, i);
        end
      end
    end
  end

  // One-hot form of the grant; a re-spike on a pending, ungranted column is lost.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[grant_idx] = 1'b1;
  end

  assign drop = |(spike_in & pending & ~grant_mask);

  // Pending bits and captured timestamps; a granted column may re-arm in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      for (int unsigned j = 0; j < NUM_COLS; j++) ts_reg[j] <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | spike_in;
      for (int unsigned j = 0; j < NUM_COLS; j++) begin
        if (spike_in[j] && (!pending[j] || grant_mask[j])) ts_reg[j] <= ts_cnt;
      end
    end
  end

  // Rotating pointer moves just past the granted column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (32'(grant_idx) == NUM_COLS - 1) ? '0 : grant_idx + ADDR_W'(1);
    end
  end

  // Sticky overflow: a drop in the same cycle beats the clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_addr[k] <= '0;
        fifo_time[k] <= '0;
      end
    end else begin
      if (grant) begin
        fifo_addr[wr_ptr] <= grant_idx;
        fifo_time[wr_ptr] <= ts_reg[grant_idx];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({grant, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Testbench for spike_event_encoder (4 columns, 4-bit timestamps, 8-entry FIFO).
module tb_spike_event_encoder;

  localparam int unsigned NC  = 4;
  localparam int unsigned TSW = 4;
  localparam int unsigned FD  = 8;
  localparam int unsigned AW  = 2;
  localparam int unsigned LW  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NC-1:0]  spike_in = '0;
  logic           clear_overflow = 1'b0;
  logic           event_ready = 1'b0;
  logic           event_valid;
  logic [AW-1:0]  event_addr;
  logic [TSW-1:0] event_time;
  logic           overflow;
  logic [LW-1:0]  fifo_level;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [TSW-1:0] ts;
  } ev_t;

  typedef struct {
    logic [NC-1:0] spk;
    int unsigned   n;
    logic [7:0]    order;
  } vec_t;

  ev_t            sb[$];
  ev_t            mon_e;
  vec_t           tbl[8];
  logic [TSW-1:0] model_cnt;
  logic [TSW-1:0] ts_a;

  spike_event_encoder #(
    .NUM_COLS  (NC),
    .TS_WIDTH  (TSW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .spike_in      (spike_in),
    .clear_overflow(clear_overflow),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_addr    (event_addr),
    .event_time    (event_time),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cnt <= '0;
    else        model_cnt <= model_cnt + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted event must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && event_valid && event_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got addr=%0d time=%0d expected none", event_addr, event_time);
      end else begin
        mon_e = sb.pop_front();
        check("event_addr", 32'(event_addr), 32'(mon_e.addr));
        check("event_time", 32'(event_time), 32'(mon_e.ts));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [NC-1:0] s);
    spike_in = s;
    tick();
    spike_in = '0;
  endtask

  task automatic push_ev(input logic [AW-1:0] a, input logic [TSW-1:0] t);
    sb.push_back(ev_t'{addr: a, ts: t});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check({"drain_", name}, 32'(sb.size()), 0);
    tick();
    tick();
    check({"idle_", name}, 32'(event_valid), 0);
  endtask

  task automatic wait_cnt(input logic [TSW-1:0] target);
    int n = 0;
    while (model_cnt != target && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt: got %0d expected %0d", model_cnt, target);
    end
  endtask

  initial begin
    // Expected grant orders packed two bits per event, first event in [1:0].
    tbl[0] = '{spk: 4'b0100, n: 1, order: 8'h02}; // ptr 3 -> 2
    tbl[1] = '{spk: 4'b1000, n: 1, order: 8'h03}; // ptr 3 -> 3
    tbl[2] = '{spk: 4'b1111, n: 4, order: 8'hE4}; // ptr 0 -> 0,1,2,3
    tbl[3] = '{spk: 4'b1001, n: 2, order: 8'h0C}; // ptr 0 -> 0,3
    tbl[4] = '{spk: 4'b0110, n: 2, order: 8'h09}; // ptr 0 -> 1,2
    tbl[5] = '{spk: 4'b0011, n: 2, order: 8'h04}; // ptr 3 -> 0,1
    tbl[6] = '{spk: 4'b1010, n: 2, order: 8'h07}; // ptr 2 -> 3,1
    tbl[7] = '{spk: 4'b0101, n: 2, order: 8'h02}; // ptr 2 -> 2,0

    // Reset state
    #12;
    check("rst_valid", 32'(event_valid), 0);
    check("rst_addr", 32'(event_addr), 0);
    check("rst_time", 32'(event_time), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(fifo_level), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    event_ready = 1'b1;

    // Single spike latency: column 2 at counter 10
    wait_cnt(4'd10);
    push_ev(2'd2, 4'd10);
    spike_in = 4'b0100;
    @(negedge clk);
    check("lat_valid_c0", 32'(event_valid), 0);
    @(posedge clk);
    #1;
    spike_in = '0;
    @(negedge clk);
    check("lat_valid_c1", 32'(event_valid), 0);
    @(negedge clk);
    check("lat_valid_c2", 32'(event_valid), 1);
    check("lat_addr_c2", 32'(event_addr), 2);
    check("lat_time_c2", 32'(event_time), 10);
    @(negedge clk);
    check("lat_valid_c3", 32'(event_valid), 0);
    check("lat_level_c3", 32'(fifo_level), 0);
    tick();

    // Round-robin table
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++) push_ev(tbl[i].order[2*k +: 2], model_cnt);
      spike(tbl[i].spk);
      drain($sformatf("rr%0d", i));
    end

    // Backpressure: 10 spikes, FIFO saturates at 8, two stay pending
    event_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_ev(AW'(i % 4), model_cnt);
      spike(NC'(1 << (i % 4)));
    end
    repeat (3) tick();
    check("bp_level_full", 32'(fifo_level), 8);
    check("bp_head_addr", 32'(event_addr), 32'(sb[0].addr));
    check("bp_head_time", 32'(event_time), 32'(sb[0].ts));
    repeat (2) tick();
    check("bp_level_hold", 32'(fifo_level), 8);
    check("bp_head_addr_hold", 32'(event_addr), 32'(sb[0].addr));
    check("bp_head_time_hold", 32'(event_time), 32'(sb[0].ts));
    check("bp_overflow", 32'(overflow), 0);
    event_ready = 1'b1;
    drain("bp");
    check("bp_overflow_end", 32'(overflow), 0);

    // Drop and sticky overflow
    event_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_ev(AW'(i % 4), model_cnt);
      spike(NC'(1 << (i % 4)));
    end
    repeat (2) tick();
    check("drop_level_full", 32'(fifo_level), 8);
    ts_a = model_cnt;
    push_ev(2'd1, ts_a);
    spike(4'b0010);
    check("drop_first_no_ovf", 32'(overflow), 0);
    spike(4'b0010);
    check("drop_ovf_set", 32'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("drop_clear", 32'(overflow), 0);
    clear_overflow = 1'b1;
    spike(4'b0010);
    clear_overflow = 1'b0;
    check("drop_set_beats_clear", 32'(overflow), 1);
    event_ready = 1'b1;
    drain("drop");
    check("drop_ovf_sticky", 32'(overflow), 1);

    // Counter wrap
    wait_cnt(4'd15);
    push_ev(2'd2, 4'd15);
    spike(4'b0100);
    push_ev(2'd3, 4'd0);
    spike(4'b1000);
    drain("wrap");

    // Async reset with 5 events queued
    event_ready = 1'b0;
    for (int i = 0; i < 5; i++) spike(NC'(1 << (i % 4)));
    repeat (2) tick();
    check("mid_level_pre", 32'(fifo_level), 5);
    check("mid_ovf_pre", 32'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(event_valid), 0);
    check("mid_level", 32'(fifo_level), 0);
    check("mid_overflow", 32'(overflow), 0);
    check("mid_addr", 32'(event_addr), 0);
    check("mid_time", 32'(event_time), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    event_ready = 1'b1;
    push_ev(2'd2, 4'd0);
    spike_in = 4'b0100;
    @(posedge clk);
    #1;
    spike_in = '0;
    tick();
    tick();
    push_ev(2'd1, 4'd3);
    spike(4'b0010);
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_event_encoder.md
# spike_event_encoder

Converts the per-column output spike pulses of the neuron array into a serial stream of address-events. Each event carries the column index and a timestamp. The block sits directly downstream of the `nn` array's neuron columns and upstream of the off-chip event link. Buffering and backpressure are handled through a valid/ready interface. Spike pulses are latched per column, arbitrated round-robin, and queued in an event FIFO.

## Interface

Parameters:
- NUM_COLS, 1: number of neuron columns (spike inputs).
- TS_WIDTH, 16: timestamp width in bits.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- ADDR_W (derived): max(1, $clog2(NUM_COLS)).

Ports:
- clk, input, 1: main clock; all state is clocked on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- spike_in, input, NUM_COLS: single-cycle spike pulses, one bit per neuron column.
- clear_overflow, input, 1: clears the sticky overflow flag.
- event_valid, output, 1: the head FIFO entry is available.
- event_ready, input, 1: the consumer accepts the head entry.
- event_addr, output, ADDR_W: column index of the head event.
- event_time, output, TS_WIDTH: timestamp of the head event.
- overflow, output, 1: sticky; at least one spike has been lost.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current number of FIFO entries.

## Operation

- **Timestamp counter:** free-running TS_WIDTH-bit counter, +1 every cycle, wraps from 2^TS_WIDTH−1 to 0.
- **Pending stage:** one pending bit plus one TS_WIDTH timestamp register per column.
  - When spike_in[j] is sampled high, pending[j] is set and the current counter value is captured.
  - A spike on a column whose pending bit is already set, and which is not granted in that cycle, is dropped. The original timestamp is kept and overflow is set.
  - If a column is granted and spikes in the same cycle, pending stays set, the new timestamp is captured, and no drop occurs.
- **Arbiter:** combinational from pending, the rotating pointer ptr, and the FIFO full flag.
  - The grant goes to the first pending column at index ≥ ptr, wrapping modulo NUM_COLS.
  - At most one grant per cycle. No grant while the FIFO is full, where full is evaluated on the registered count; a simultaneous pop does not enable a grant.
  - On a grant to column g: {g, ts[g]} is pushed into the FIFO, pending[g] is cleared, and ptr becomes (g+1) mod NUM_COLS.
  - With no grant, ptr holds.
- **FIFO:** synchronous, registered head.
  - event_valid = (fifo_level != 0).
  - A pop occurs when event_valid && event_ready.
  - A push and a pop may occur in the same cycle; fifo_level is then unchanged.
  - event_addr and event_time stay stable while event_valid && !event_ready.
- **Overflow:**
  - Set by any dropped spike.
  - Cleared by clear_overflow when no drop occurs in the same cycle; set wins over clear.
  - Pending spikes remain queued while the FIFO is full; loss occurs only through the re-spike rule above.

## Timing

- **Reset (asynchronous, active-low):** pending=0, all timestamp registers=0, counter=0, ptr=0, FIFO empty. Outputs: event_valid=0, event_addr=0, event_time=0, overflow=0, fifo_level=0.
- **Reset mid-operation:** all queued and pending events are discarded. The counter restarts at 0 on the first edge after release.
- **Latency:** a spike sampled at edge k sets pending after edge k; the grant and push occur at edge k+1; event_valid is high in the cycle after edge k+1. Minimum latency is 2 cycles from the spike cycle. The timestamp equals the counter value during the spike cycle.
- **Throughput:** 1 event per cycle into and out of the FIFO when event_ready=1.
- **Fairness:** with N columns continuously pending, each column is served at least once every N grants.
- **Counter wrap:** the timestamp is a raw wrapped value; there is no epoch marker.

## Test plan

- **Single spike latency:** NUM_COLS=4, reset released, spike_in=4'b0100 in cycle 10 (counter=10), event_ready=1.
  - event_valid is high in cycle 12 with event_addr=2 and event_time=10; it falls after one cycle.
- **Simultaneous spikes, round-robin:** spike_in=4'b1111 in one cycle with ptr=0.
  - Events are emitted in order addr 0,1,2,3 on consecutive cycles, all with the same timestamp.
  - A following spike_in=4'b1001 yields addr 0 then 3.
- **Backpressure/full:** FIFO_DEPTH=8, event_ready=0, 10 spikes spread over distinct columns and cycles.
  - fifo_level saturates at 8 and the remaining events stay pending.
  - With event_ready then held at 1, all 10 events emerge in the same order with their original timestamps, and overflow=0.
- **Drop and sticky overflow:** event_ready=0 with the FIFO full, column 1 spiked twice.
  - overflow=1, and only the first timestamp is later delivered.
  - clear_overflow asserted with no drop clears overflow; clear_overflow asserted together with a drop keeps it at 1.
- **Counter wrap:** TS_WIDTH=4, spike in the cycle where counter=15 and a second spike in the following cycle.
  - event_time values are 15 then 0.
- **Async reset mid-stream:** reset asserted low between clock edges with 5 events queued.
  - Immediately: event_valid=0, fifo_level=0, overflow=0.
  - After release, a new spike gets a timestamp relative to counter restart at 0.
